playback_sequencer: RTL and testbench

PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

---
 rtl/playback_sequencer.sv | 130 +++++++++++++
 tb/tb_playback_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/playback_sequencer.sv
// Steps through a note RAM at a fixed tempo, sounding each entry with a short
// silent gap at the end of the step, optionally looping back to entry 0.
module playback_sequencer #(
    parameter int TICKS_PER_STEP = 25000000,
    parameter int GAP_TICKS      = 2500000,
    parameter int DEPTH          = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play,
    input  logic       loop_en,
    input  logic [5:0] num_notes,
    output logic [5:0] rd_addr,
    input  logic [5:0] rd_data,
    output logic [5:0] note_code,
    output logic       note_on,
    output logic [5:0] step_pos,
    output logic       playing,
    output logic       done
);

    localparam int CNT_W = (TICKS_PER_STEP > 2) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICKS_PER_STEP - 1);
    localparam logic [CNT_W-1:0] ON_CNT   = CNT_W'(TICKS_PER_STEP - GAP_TICKS);

    typedef enum logic [1:0] {IDLE, FETCH, STEP, HOLD} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [5:0]       step_pos_nx;
    logic [5:0]       note_code_nx;
    logic [5:0]       n_lat, n_lat_nx;
    logic [5:0]       eff_count;
    logic [5:0]       nxt;
    logic             last_entry;
    logic             last_tick;

    // Compositions longer than the RAM are limited to its depth.
    function automatic logic [5:0] clamp_count(input logic [5:0] n);
        if (int'(n) > DEPTH)
            return 6'(DEPTH);
        return n;
    endfunction

    assign eff_count  = clamp_count(num_notes);
    assign last_entry = (step_pos == n_lat - 6'd1);
    assign last_tick  = (cnt == LAST_CNT);
    assign nxt        = last_entry ? 6'd0 : step_pos + 6'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            step_pos  <= '0;
            note_code <= '0;
            n_lat     <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            step_pos  <= step_pos_nx;
            note_code <= note_code_nx;
            n_lat     <= n_lat_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        step_pos_nx  = step_pos;
        note_code_nx = note_code;
        n_lat_nx     = n_lat;
        rd_addr      = 6'd0;
        note_on      = 1'b0;
        playing      = 1'b0;
        done         = 1'b0;

        case (state)
            IDLE: begin
                if (play && (eff_count != 6'd0)) begin
                    n_lat_nx = eff_count;
                    state_nx = FETCH;
                end
            end

            FETCH: begin
                playing = 1'b1;
                if (!play) begin
                    state_nx    = IDLE;
                    step_pos_nx = 6'd0;
                end else begin
                    state_nx     = STEP;
                    note_code_nx = rd_data;
                    step_pos_nx  = 6'd0;
                    cnt_nx       = '0;
                end
            end

            STEP: begin
                playing = 1'b1;
                // Address the following entry for the whole step so the RAM
                // word is ready by the boundary.
                rd_addr = nxt;
                note_on = (cnt < ON_CNT);
                if (!play) begin
                    state_nx    = IDLE;
                    step_pos_nx = 6'd0;
                    cnt_nx      = '0;
                end else if (!last_tick) begin
                    cnt_nx = cnt + CNT_W'(1);
                end else if (!last_entry || loop_en) begin
                    step_pos_nx  = nxt;
                    note_code_nx = rd_data;
                    cnt_nx       = '0;
                end else begin
                    done     = 1'b1;
                    cnt_nx   = '0;
                    state_nx = HOLD;
                end
            end

            HOLD: begin
                if (!play)
                    state_nx = IDLE;
            end

            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_playback_sequencer.sv
// Randomized bench for playback_sequencer with a timeline-based reference model
// (TICKS_PER_STEP=8, GAP_TICKS=2, DEPTH=40, 1-cycle RAM).
module tb_playback_sequencer;

    localparam int TPS   = 8;
    localparam int GAP   = 2;
    localparam int DEPTH = 40;
    localparam int NEVER = 1000000;

    logic       clk;
    logic       reset;
    logic       play;
    logic       loop_en;
    logic [5:0] num_notes;
    logic [5:0] rd_addr;
    logic [5:0] rd_data;
    logic [5:0] note_code;
    logic       note_on;
    logic [5:0] step_pos;
    logic       playing;
    logic       done;

    logic [5:0] ram [64];
    int n_checks = 0;
    int n_fail   = 0;

    playback_sequencer #(
        .TICKS_PER_STEP(TPS),
        .GAP_TICKS(GAP),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .play(play),
        .loop_en(loop_en),
        .num_notes(num_notes),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .note_code(note_code),
        .note_on(note_on),
        .step_pos(step_pos),
        .playing(playing),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= ram[rd_addr];

    typedef struct packed {
        logic       on;
        logic       ply;
        logic       dn;
        logic       dchk;
        logic [5:0] code;
        logic [5:0] pos;
    } exp_t;

    // Timeline view: rel 0 = cycle play is sampled in IDLE, rel 1 = fetch,
    // then step k occupies rel 2+TPS*k .. 2+TPS*k+TPS-1. Play low at rel
    // 'stop' ends playback from rel stop+1 on, with no done in that cycle.
    function automatic exp_t model(int rel, int n, bit lp, int stop);
        exp_t e;
        int t, k, ph;
        e = '0;
        if (rel < 0 || rel > stop) return e;
        if (rel == 1) e.ply = 1'b1;
        if (rel >= 2) begin
            t  = rel - 2;
            k  = t / TPS;
            ph = t % TPS;
            if (lp || k < n) begin
                e.ply  = 1'b1;
                e.dchk = 1'b1;
                e.on   = (ph < TPS - GAP);
                e.pos  = 6'(k % n);
                e.code = ram[k % n];
                e.dn   = !lp && (k == n - 1) && (ph == TPS - 1) && (rel != stop);
            end
        end
        return e;
    endfunction

    task automatic settle();
        play = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; play = 1'b1; loop_en = 1'b1; num_notes = 6'd3;
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if ({note_on, playing, done, rd_addr, step_pos, note_code} !== 21'd0) begin
                n_fail++;
                $display("FAIL reset outputs got %b required 0",
                         {note_on, playing, done, rd_addr, step_pos, note_code});
            end
        end
        @(posedge clk); #1;
        play = 1'b0; loop_en = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        exp_t e;
        ram[0] = 6'd5; ram[1] = 6'd17; ram[2] = 6'd40;
        num_notes = 6'd3; loop_en = 1'b0; play = 1'b1;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            e = model(c, 3, 1'b0, NEVER);
            n_checks++;
            if ({note_on, playing, done} !== {e.on, e.ply, e.dn}) begin
                n_fail++;
                $display("FAIL basic c=%0d on/playing/done got %b required %b",
                         c, {note_on, playing, done}, {e.on, e.ply, e.dn});
            end
            if (e.dchk) begin
                n_checks++;
                if ({step_pos, note_code} !== {e.pos, e.code}) begin
                    n_fail++;
                    $display("FAIL basic c=%0d pos/code got %0d/%0d required %0d/%0d",
                             c, step_pos, note_code, e.pos, e.code);
                end
            end
            @(posedge clk); #1;
        end
        settle();
    endtask

    task automatic test_loop();
        exp_t e;
        num_notes = 6'd3; loop_en = 1'b1; play = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            e = model(c, 3, 1'b1, NEVER);
            n_checks++;
            if ({note_on, playing, done} !== {e.on, e.ply, e.dn}) begin
                n_fail++;
                $display("FAIL loop c=%0d on/playing/done got %b required %b",
                         c, {note_on, playing, done}, {e.on, e.ply, e.dn});
            end
            if (e.dchk) begin
                n_checks++;
                if ({step_pos, note_code} !== {e.pos, e.code}) begin
                    n_fail++;
                    $display("FAIL loop c=%0d pos/code got %0d/%0d required %0d/%0d",
                             c, step_pos, note_code, e.pos, e.code);
                end
            end
            @(posedge clk); #1;
        end
        settle();
        loop_en = 1'b0;
    endtask

    task automatic test_stop();
        exp_t e;
        num_notes = 6'd3; loop_en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            play = (c < 12);
            @(negedge clk);
            e = model(c, 3, 1'b0, 12);
            n_checks++;
            if ({note_on, playing, done} !== {e.on, e.ply, e.dn}) begin
                n_fail++;
                $display("FAIL stop c=%0d on/playing/done got %b required %b",
                         c, {note_on, playing, done}, {e.on, e.ply, e.dn});
            end
            if (e.dchk || c == 13) begin
                n_checks++;
                if (step_pos !== (c == 13 ? 6'd0 : e.pos)) begin
                    n_fail++;
                    $display("FAIL stop c=%0d step_pos got %0d required %0d",
                             c, step_pos, (c == 13 ? 6'd0 : e.pos));
                end
            end
            @(posedge clk); #1;
        end
        play = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            e = model(c, 3, 1'b0, NEVER);
            n_checks++;
            if ({note_on, playing, done, e.dchk ? {step_pos, note_code} : 12'd0}
                !== {e.on, e.ply, e.dn, e.pos, e.code}) begin
                n_fail++;
                $display("FAIL replay c=%0d on/ply/dn/pos/code got %b/%0d/%0d required %b/%0d/%0d",
                         c, {note_on, playing, done}, step_pos, note_code,
                         {e.on, e.ply, e.dn}, e.pos, e.code);
            end
            @(posedge clk); #1;
        end
        settle();
    endtask

    task automatic test_empty();
        num_notes = 6'd0; loop_en = 1'b0; play = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            n_checks++;
            if ({note_on, playing, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL empty c=%0d on/playing/done got %b required 000",
                         c, {note_on, playing, done});
            end
            @(posedge clk); #1;
        end
        settle();
    endtask

    task automatic test_clamp();
        exp_t e;
        for (int i = 0; i < 64; i++) ram[i] = 6'($urandom);
        num_notes = 6'd63; loop_en = 1'b0; play = 1'b1;
        for (int c = 0; c < 2 + TPS * DEPTH + 4; c++) begin
            if (c == 20) num_notes = 6'd1;
            @(negedge clk);
            e = model(c, DEPTH, 1'b0, NEVER);
            n_checks++;
            if ({note_on, playing, done} !== {e.on, e.ply, e.dn}) begin
                n_fail++;
                $display("FAIL clamp c=%0d on/playing/done got %b required %b",
                         c, {note_on, playing, done}, {e.on, e.ply, e.dn});
            end
            if (e.dchk) begin
                n_checks++;
                if ({step_pos, note_code} !== {e.pos, e.code}) begin
                    n_fail++;
                    $display("FAIL clamp c=%0d pos/code got %0d/%0d required %0d/%0d",
                             c, step_pos, note_code, e.pos, e.code);
                end
            end
            @(posedge clk); #1;
        end
        settle();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int i = 0; i < 4; i++) ram[i] = 6'($urandom);
        num_notes = 6'd4; loop_en = 1'b0; play = 1'b1;
        for (int c = 0; c < 30; c++) begin
            reset = (c == 13);
            @(negedge clk);
            if (c != 13) begin
                e = (c < 13) ? model(c, 4, 1'b0, NEVER) : model(c - 14, 4, 1'b0, NEVER);
                n_checks++;
                if ({note_on, playing, done} !== {e.on, e.ply, e.dn}) begin
                    n_fail++;
                    $display("FAIL reset_mid c=%0d on/playing/done got %b required %b",
                             c, {note_on, playing, done}, {e.on, e.ply, e.dn});
                end
                if (e.dchk || c == 14) begin
                    n_checks++;
                    if ({step_pos, note_code} !== (c == 14 ? 12'd0 : {e.pos, e.code})) begin
                        n_fail++;
                        $display("FAIL reset_mid c=%0d pos/code got %0d/%0d required %0d/%0d",
                                 c, step_pos, note_code,
                                 (c == 14 ? 6'd0 : e.pos), (c == 14 ? 6'd0 : e.code));
                    end
                end
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        settle();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int n, stop;
        bit lp;
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 8; i++) ram[i] = 6'($urandom);
            n    = int'($urandom_range(1, 6));
            lp   = 1'($urandom_range(0, 1));
            stop = int'($urandom_range(1, 2 + TPS * n + 3));
            num_notes = 6'(n);
            loop_en   = lp;
            for (int c = 0; c <= stop + 1; c++) begin
                play = (c < stop);
                if (c > 0) num_notes = 6'($urandom);
                @(negedge clk);
                e = model(c, n, lp, stop);
                n_checks++;
                if ({note_on, playing, done} !== {e.on, e.ply, e.dn}) begin
                    n_fail++;
                    $display("FAIL b2b it=%0d n=%0d lp=%0d c=%0d on/playing/done got %b required %b",
                             it, n, lp, c, {note_on, playing, done}, {e.on, e.ply, e.dn});
                end
                if (e.dchk) begin
                    n_checks++;
                    if ({step_pos, note_code} !== {e.pos, e.code}) begin
                        n_fail++;
                        $display("FAIL b2b it=%0d c=%0d pos/code got %0d/%0d required %0d/%0d",
                                 it, c, step_pos, note_code, e.pos, e.code);
                    end
                end
                @(posedge clk); #1;
            end
        end
        settle();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 6'd0;
        reset = 1'b1; play = 1'b0; loop_en = 1'b0; num_notes = 6'd0;
        test_reset();
        test_basic();
        test_loop();
        test_stop();
        test_empty();
        test_clamp();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
